// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus start sequencer feeding the Uart8 transmitter.
// Launches one byte at a time and paces each launch on the transmitter's busy flag.
module uart_tx_feeder #(
  parameter int DEPTH     = 16,
  parameter int START_TMO = 65535
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic [7:0]               wrData,
  input  logic                     wrValid,
  output logic                     wrReady,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     txEn,
  output logic                     txStart,
  output logic [7:0]               txData,
  input  logic                     txBusy,
  output logic                     stallErr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] TMO_LAST = 16'(START_TMO - 1);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    GAP
  } state_t;

  state_t state;
  state_t stateNxt;

  logic          busyQ;
  logic          busyS;
  logic          alive;
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wrPtr;
  logic [AW:0]   rdPtr;
  logic [15:0]   tmo;
  logic          full;
  logic          empty;
  logic          doWr;
  logic          doPop;
  logic          tmoHit;

  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[AW] != rdPtr[AW]) &&
                   (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign wrReady = rstn && alive && !full;
  assign level   = wrPtr - rdPtr;
  assign doWr    = wrValid && wrReady;
  assign doPop   = (state == IDLE) && en && !empty && !busyS;
  assign tmoHit  = (tmo == TMO_LAST);

  // Two-flop synchronizer for the txClk-domain busy flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busyQ <= 1'b0;
      busyS <= 1'b0;
    end else begin
      busyQ <= txBusy;
      busyS <= busyQ;
    end
  end

  // FIFO pointers; alive holds wrReady low until the cycle after reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (doWr) wrPtr <= wrPtr + PTR_ONE;
      if (doPop) rdPtr <= rdPtr + PTR_ONE;
    end
  end

  // FIFO storage, written only on an accepted byte
  always_ff @(posedge clk) begin
    if (doWr) mem[wrPtr[AW-1:0]] <= wrData;
  end

  // Head byte is captured on pop and held until the next launch
  always_ff @(posedge clk) begin
    if (!rstn) txData <= 8'h00;
    else if (doPop) txData <= mem[rdPtr[AW-1:0]];
  end

  // Start timeout counter runs only while waiting for busy to rise
  always_ff @(posedge clk) begin
    if (!rstn || state != START) tmo <= '0;
    else tmo <= tmo + 16'd1;
  end

  // Sticky stall flag; a busy rise on the last cycle still wins
  always_ff @(posedge clk) begin
    if (!rstn) stallErr <= 1'b0;
    else if (state == START && !busyS && tmoHit) stallErr <= 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else state <= stateNxt;
  end

  // Next-state logic
  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:  if (doPop) stateNxt = START;
      START: if (busyS || tmoHit) stateNxt = WAIT;
      WAIT:  if (!busyS) stateNxt = GAP;
      GAP:   stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Uart8 control outputs decoded from state
  always_comb begin
    txEn    = 1'b0;
    txStart = 1'b0;
    unique case (state)
      IDLE:  ;
      START: begin
        txEn    = 1'b1;
        txStart = 1'b1;
      end
      WAIT:  txEn = 1'b1;
      GAP:   txEn = 1'b1;
      default: ;
    endcase
  end

endmodule
